// File: rtl/cache_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Purpose : shared types and helpers for the cache/memory arbiter.
//   ch_state_e  - per-channel transaction state
//   idx_width() - width of a consumer index, never less than one bit
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [2:0] {
    CH_IDLE           = 3'd0,
    CH_READ_WAITING   = 3'd1,
    CH_WRITE_WAITING  = 3'd2,
    CH_READ_RELAYING  = 3'd3,
    CH_WRITE_RELAYING = 3'd4
  } ch_state_e;

  // A single consumer still needs a one-bit index so the index vectors stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter_if
// Purpose : bundles the consumer-side (dcache fill/writeback) and memory-side
//           (per-channel) handshakes of the arbiter.
// Modports:
//   slave  - arbiter view: consumer requests and memory responses in,
//            consumer responses and memory requests out
//   master - environment view (dcache controllers plus memory), the mirror
// ---------------------------------------------------------------------------
interface cache_mem_arbiter_if #(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 8,
  parameter int unsigned NUM_CHANNELS  = 4
);

  // consumer side
  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

  // memory side
  logic [NUM_CHANNELS-1:0]                 mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
  logic [NUM_CHANNELS-1:0]                 mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
  logic [NUM_CHANNELS-1:0]                 mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
  logic [NUM_CHANNELS-1:0]                 mem_write_ready;

  modport slave (
    input  consumer_read_valid, consumer_read_address,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport master (
    output consumer_read_valid, consumer_read_address,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );

endinterface

// File: rtl/cache_mem_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Purpose : purely combinational round-robin search. Returns the first set bit
//           of req_mask_i at or after ptr_i, wrapping at N.
// Ports:
//   req_mask_i - candidate consumers
//   ptr_i      - search start position
//   found_o    - a candidate exists
//   idx_o      - index of that candidate (0 when none)
// ---------------------------------------------------------------------------
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req_mask_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // Walk the ring from ptr_i; the first hit latches and later hits are masked.
  always_comb begin
    found_o = 1'b0;
    idx_o   = {IDX_W{1'b0}};
    cand_s  = {IDX_W{1'b0}};
    hit_s   = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      cand_s  = IDX_W'((int'(ptr_i) + i) % int'(N));
      hit_s   = req_mask_i[cand_s] & ~found_o;
      idx_o   = hit_s ? cand_s : idx_o;
      found_o = found_o | hit_s;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
// Purpose : shares NUM_CHANNELS memory channels among NUM_CONSUMERS dcache
//           fill/writeback ports. Each channel runs its own small FSM, claims
//           one consumer at a time round-robin, forwards the request to memory
//           one cycle later and relays the response back until the consumer
//           drops its valid.
// Ports:
//   clk   - clock, all state on the rising edge
//   reset - asynchronous active-low reset
//   bus   - cache_mem_arbiter_if.slave (consumer and memory handshakes)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module cache_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned NUM_CONSUMERS = 8,
  parameter int unsigned NUM_CHANNELS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_mem_arbiter_if.slave   bus
);

  localparam int unsigned      IDX_W    = idx_width(NUM_CONSUMERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONSUMERS - 1);

  // per-channel state
  ch_state_e                              state_q [NUM_CHANNELS];
  ch_state_e                              state_d [NUM_CHANNELS];
  logic [IDX_W-1:0]                       owner_q [NUM_CHANNELS];
  logic [IDX_W-1:0]                       owner_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]                abort_q, abort_d;
  logic [NUM_CHANNELS-1:0]                mem_rd_valid_q, mem_rd_valid_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic [NUM_CHANNELS-1:0]                mem_wr_valid_q, mem_wr_valid_d;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_wr_addr_q, mem_wr_addr_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_wr_data_q, mem_wr_data_d;

  // per-consumer state
  logic [NUM_CONSUMERS-1:0]                rd_ready_q, rd_ready_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic [NUM_CONSUMERS-1:0]                wr_ready_q, wr_ready_d;
  logic [NUM_CONSUMERS-1:0]                claimed_q, claimed_d;
  logic [IDX_W-1:0]                        rr_ptr_q, rr_ptr_d;

  // arbitration
  logic [NUM_CONSUMERS-1:0] req_mask_s;
  logic                     pick_take_s [NUM_CHANNELS];
  logic [IDX_W-1:0]         pick_idx_s  [NUM_CHANNELS];

  assign req_mask_s = (bus.consumer_read_valid | bus.consumer_write_valid) & ~claimed_q;

  // Picker chain: each channel sees the pending mask minus what lower channels
  // are taking this cycle, so one cycle can never hand a consumer out twice.
  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    logic [NUM_CONSUMERS-1:0] mask_in_s;
    logic                     found_s;
    logic [IDX_W-1:0]         idx_s;
    logic                     take_s;

    if (ch == 0) begin : g_first
      assign mask_in_s = req_mask_s;
    end else begin : g_next
      assign mask_in_s = g_ch[ch-1].take_s
                       ? (g_ch[ch-1].mask_in_s &
                          ~(NUM_CONSUMERS'(1) << g_ch[ch-1].idx_s))
                       : g_ch[ch-1].mask_in_s;
    end

    rr_picker #(
      .N     (NUM_CONSUMERS),
      .IDX_W (IDX_W)
    ) u_rr_picker (
      .req_mask_i (mask_in_s),
      .ptr_i      (rr_ptr_q),
      .found_o    (found_s),
      .idx_o      (idx_s)
    );

    // Busy channels still compute a pick but must not consume it.
    assign take_s          = found_s & (state_q[ch] == CH_IDLE);
    assign pick_take_s[ch] = take_s;
    assign pick_idx_s[ch]  = idx_s;
  end

  // Next-state and next-output logic for every channel FSM and shared state.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    abort_d        = abort_q;
    mem_rd_valid_d = mem_rd_valid_q;
    mem_rd_addr_d  = mem_rd_addr_q;
    mem_wr_valid_d = mem_wr_valid_q;
    mem_wr_addr_d  = mem_wr_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
    rd_ready_d     = rd_ready_q;
    rd_data_d      = rd_data_q;
    wr_ready_d     = wr_ready_q;
    claimed_d      = claimed_q;
    rr_ptr_d       = rr_ptr_q;

    for (int ch = 0; ch < int'(NUM_CHANNELS); ch++) begin
      case (state_q[ch])
        CH_IDLE: begin
          if (pick_take_s[ch]) begin
            owner_d[ch]                = pick_idx_s[ch];
            claimed_d[pick_idx_s[ch]]  = 1'b1;
            abort_d[ch]                = 1'b0;
            // Later channels overwrite this, so the pointer follows the last grant.
            rr_ptr_d = (pick_idx_s[ch] == LAST_IDX) ? {IDX_W{1'b0}}
                                                    : pick_idx_s[ch] + IDX_W'(1);
            // A writeback takes priority over a fill from the same consumer.
            if (bus.consumer_write_valid[pick_idx_s[ch]]) begin
              mem_wr_valid_d[ch] = 1'b1;
              mem_wr_addr_d[ch]  = bus.consumer_write_address[pick_idx_s[ch]];
              mem_wr_data_d[ch]  = bus.consumer_write_data[pick_idx_s[ch]];
              state_d[ch]        = CH_WRITE_WAITING;
            end else begin
              mem_rd_valid_d[ch] = 1'b1;
              mem_rd_addr_d[ch]  = bus.consumer_read_address[pick_idx_s[ch]];
              state_d[ch]        = CH_READ_WAITING;
            end
          end else begin
            state_d[ch] = CH_IDLE;
          end
        end

        CH_READ_WAITING: begin
          if (bus.mem_read_ready[ch]) begin
            mem_rd_valid_d[ch] = 1'b0;
            // An abandoned request still finishes on the memory side but is not relayed.
            if (abort_q[ch] || !bus.consumer_read_valid[owner_q[ch]]) begin
              claimed_d[owner_q[ch]] = 1'b0;
              state_d[ch]            = CH_IDLE;
            end else begin
              rd_ready_d[owner_q[ch]] = 1'b1;
              rd_data_d[owner_q[ch]]  = bus.mem_read_data[ch];
              state_d[ch]             = CH_READ_RELAYING;
            end
          end else begin
            abort_d[ch] = abort_q[ch] | ~bus.consumer_read_valid[owner_q[ch]];
          end
        end

        CH_WRITE_WAITING: begin
          if (bus.mem_write_ready[ch]) begin
            mem_wr_valid_d[ch] = 1'b0;
            if (abort_q[ch] || !bus.consumer_write_valid[owner_q[ch]]) begin
              claimed_d[owner_q[ch]] = 1'b0;
              state_d[ch]            = CH_IDLE;
            end else begin
              wr_ready_d[owner_q[ch]] = 1'b1;
              state_d[ch]             = CH_WRITE_RELAYING;
            end
          end else begin
            abort_d[ch] = abort_q[ch] | ~bus.consumer_write_valid[owner_q[ch]];
          end
        end

        CH_READ_RELAYING: begin
          if (!bus.consumer_read_valid[owner_q[ch]]) begin
            rd_ready_d[owner_q[ch]] = 1'b0;
            claimed_d[owner_q[ch]]  = 1'b0;
            state_d[ch]             = CH_IDLE;
          end else begin
            state_d[ch] = CH_READ_RELAYING;
          end
        end

        CH_WRITE_RELAYING: begin
          if (!bus.consumer_write_valid[owner_q[ch]]) begin
            wr_ready_d[owner_q[ch]] = 1'b0;
            claimed_d[owner_q[ch]]  = 1'b0;
            state_d[ch]             = CH_IDLE;
          end else begin
            state_d[ch] = CH_WRITE_RELAYING;
          end
        end

        default: begin
          state_d[ch] = CH_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset abandons everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < int'(NUM_CHANNELS); ch++) begin
        state_q[ch] <= CH_IDLE;
        owner_q[ch] <= {IDX_W{1'b0}};
      end
      abort_q        <= {NUM_CHANNELS{1'b0}};
      mem_rd_valid_q <= {NUM_CHANNELS{1'b0}};
      mem_rd_addr_q  <= {(NUM_CHANNELS*ADDR_BITS){1'b0}};
      mem_wr_valid_q <= {NUM_CHANNELS{1'b0}};
      mem_wr_addr_q  <= {(NUM_CHANNELS*ADDR_BITS){1'b0}};
      mem_wr_data_q  <= {(NUM_CHANNELS*DATA_BITS){1'b0}};
      rd_ready_q     <= {NUM_CONSUMERS{1'b0}};
      rd_data_q      <= {(NUM_CONSUMERS*DATA_BITS){1'b0}};
      wr_ready_q     <= {NUM_CONSUMERS{1'b0}};
      claimed_q      <= {NUM_CONSUMERS{1'b0}};
      rr_ptr_q       <= {IDX_W{1'b0}};
    end else begin
      for (int ch = 0; ch < int'(NUM_CHANNELS); ch++) begin
        state_q[ch] <= state_d[ch];
        owner_q[ch] <= owner_d[ch];
      end
      abort_q        <= abort_d;
      mem_rd_valid_q <= mem_rd_valid_d;
      mem_rd_addr_q  <= mem_rd_addr_d;
      mem_wr_valid_q <= mem_wr_valid_d;
      mem_wr_addr_q  <= mem_wr_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      rd_ready_q     <= rd_ready_d;
      rd_data_q      <= rd_data_d;
      wr_ready_q     <= wr_ready_d;
      claimed_q      <= claimed_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign bus.consumer_read_ready  = rd_ready_q;
  assign bus.consumer_read_data   = rd_data_q;
  assign bus.consumer_write_ready = wr_ready_q;
  assign bus.mem_read_valid       = mem_rd_valid_q;
  assign bus.mem_read_address     = mem_rd_addr_q;
  assign bus.mem_write_valid      = mem_wr_valid_q;
  assign bus.mem_write_address    = mem_wr_addr_q;
  assign bus.mem_write_data       = mem_wr_data_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter
// Directed bench: a 4-channel arbiter for the read, writeback, write-priority,
// contention, abort and reset scenarios, plus a 1-channel arbiter for the
// round-robin fairness sequence.
// ---------------------------------------------------------------------------
module tb_cache_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cache_mem_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(4)) bus ();
  cache_mem_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(1)) bus1 ();

  cache_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  cache_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.consumer_read_valid     = '0;
    bus.consumer_read_address   = '0;
    bus.consumer_write_valid    = '0;
    bus.consumer_write_address  = '0;
    bus.consumer_write_data     = '0;
    bus.mem_read_ready          = '0;
    bus.mem_read_data           = '0;
    bus.mem_write_ready         = '0;
    bus1.consumer_read_valid    = '0;
    bus1.consumer_read_address  = '0;
    bus1.consumer_write_valid   = '0;
    bus1.consumer_write_address = '0;
    bus1.consumer_write_data    = '0;
    bus1.mem_read_ready         = '0;
    bus1.mem_read_data          = '0;
    bus1.mem_write_ready        = '0;
  endtask

  initial begin
    int   n;
    int   exp_c;
    logic [7:0] exp_a;

    checks = 0;
    errors = 0;
    reset  = 1'b0;
    clear_inputs();
    step();
    step();

    // ---- reset state
    chk("rst_rd_ready",  64'(bus.consumer_read_ready),  64'h0);
    chk("rst_rd_data",   64'(bus.consumer_read_data),   64'h0);
    chk("rst_wr_ready",  64'(bus.consumer_write_ready), 64'h0);
    chk("rst_mem_rv",    64'(bus.mem_read_valid),       64'h0);
    chk("rst_mem_wv",    64'(bus.mem_write_valid),      64'h0);
    chk("rst_mem_waddr", 64'(bus.mem_write_address),    64'h0);
    chk("rst_mem_wdata", 64'(bus.mem_write_data),       64'h0);
    chk("rst_rr_ptr",    64'(dut.rr_ptr_q),             64'h0);
    reset = 1'b1;
    step();

    // ---- single read: consumer 3 reads 0x42, memory returns 0xA5
    bus.consumer_read_valid[3]   = 1'b1;
    bus.consumer_read_address[3] = 8'h42;
    step();
    chk("rd_issue_valid", 64'(bus.mem_read_valid),      64'h1);
    chk("rd_issue_addr",  64'(bus.mem_read_address[0]), 64'h42);
    chk("rd_rr_ptr",      64'(dut.rr_ptr_q),            64'h4);
    step();
    chk("rd_hold_valid",  64'(bus.mem_read_valid),      64'h1);
    chk("rd_no_early_rdy", 64'(bus.consumer_read_ready), 64'h0);
    bus.mem_read_ready[0] = 1'b1;
    bus.mem_read_data[0]  = 8'hA5;
    step();
    bus.mem_read_ready[0] = 1'b0;
    chk("rd_ready",       64'(bus.consumer_read_ready),   64'h08);
    chk("rd_data",        64'(bus.consumer_read_data[3]), 64'hA5);
    chk("rd_valid_drop",  64'(bus.mem_read_valid),        64'h0);
    step();
    chk("rd_relay_hold",  64'(bus.consumer_read_ready),   64'h08);
    bus.consumer_read_valid[3] = 1'b0;
    step();
    chk("rd_ready_clear", 64'(bus.consumer_read_ready),   64'h0);
    chk("rd_ch_idle",     64'(dut.state_q[0]),            64'(CH_IDLE));

    // ---- writeback: consumer 5 writes 0x7F to 0x10 with 3 stall cycles
    bus.consumer_write_valid[5]   = 1'b1;
    bus.consumer_write_address[5] = 8'h10;
    bus.consumer_write_data[5]    = 8'h7F;
    step();
    for (int s = 0; s < 4; s++) begin
      chk("wr_valid_held", 64'(bus.mem_write_valid),        64'h1);
      chk("wr_addr_held",  64'(bus.mem_write_address[0]),   64'h10);
      chk("wr_data_held",  64'(bus.mem_write_data[0]),      64'h7F);
      chk("wr_no_early",   64'(bus.consumer_write_ready),   64'h0);
      if (s < 3) step();
    end
    bus.mem_write_ready[0] = 1'b1;
    step();
    bus.mem_write_ready[0] = 1'b0;
    chk("wr_ready",      64'(bus.consumer_write_ready), 64'h20);
    chk("wr_valid_drop", 64'(bus.mem_write_valid),      64'h0);
    bus.consumer_write_valid[5] = 1'b0;
    step();
    chk("wr_ready_clear", 64'(bus.consumer_write_ready), 64'h0);

    // ---- consumer 1 asserts both valids: writeback first, then fill
    bus.consumer_read_valid[1]    = 1'b1;
    bus.consumer_read_address[1]  = 8'h11;
    bus.consumer_write_valid[1]   = 1'b1;
    bus.consumer_write_address[1] = 8'h12;
    bus.consumer_write_data[1]    = 8'h34;
    step();
    chk("both_write_first", 64'(bus.mem_write_valid), 64'h1);
    chk("both_no_read",     64'(bus.mem_read_valid),  64'h0);
    bus.mem_write_ready[0] = 1'b1;
    step();
    bus.mem_write_ready[0] = 1'b0;
    chk("both_wr_ready", 64'(bus.consumer_write_ready), 64'h02);
    bus.consumer_write_valid[1] = 1'b0;
    step();
    chk("both_wr_clear", 64'(bus.consumer_write_ready), 64'h0);
    step();
    chk("both_read_next", 64'(bus.mem_read_valid),      64'h1);
    chk("both_read_addr", 64'(bus.mem_read_address[0]), 64'h11);
    bus.mem_read_ready[0] = 1'b1;
    bus.mem_read_data[0]  = 8'h66;
    step();
    bus.mem_read_ready[0] = 1'b0;
    chk("both_rd_ready", 64'(bus.consumer_read_ready), 64'h02);
    bus.consumer_read_valid[1] = 1'b0;
    step();

    // ---- contention: all eight consumers at once, four channels
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    bus.consumer_read_valid   = 8'hFF;
    bus.consumer_read_address = 64'h8786858483828180;
    step();
    chk("cont_valid_a", 64'(bus.mem_read_valid),   64'hF);
    chk("cont_addr_a",  64'(bus.mem_read_address), 64'h83828180);
    chk("cont_rr_a",    64'(dut.rr_ptr_q),         64'h4);
    bus.mem_read_ready = 4'hF;
    bus.mem_read_data  = 32'hD3D2D1D0;
    step();
    bus.mem_read_ready = 4'h0;
    chk("cont_ready_a", 64'(bus.consumer_read_ready), 64'h0F);
    chk("cont_data_a",  64'(bus.consumer_read_data[3:0]), 64'hD3D2D1D0);
    bus.consumer_read_valid = 8'hF0;
    step();
    chk("cont_clear_a", 64'(bus.consumer_read_ready), 64'h0);
    step();
    chk("cont_valid_b", 64'(bus.mem_read_valid),   64'hF);
    chk("cont_addr_b",  64'(bus.mem_read_address), 64'h87868584);
    chk("cont_rr_b",    64'(dut.rr_ptr_q),         64'h0);
    bus.mem_read_ready = 4'hF;
    bus.mem_read_data  = 32'hE3E2E1E0;
    step();
    bus.mem_read_ready = 4'h0;
    chk("cont_ready_b", 64'(bus.consumer_read_ready), 64'hF0);
    chk("cont_data_b",  64'(bus.consumer_read_data[7:4]), 64'hE3E2E1E0);
    bus.consumer_read_valid = 8'h00;
    step();
    chk("cont_clear_b", 64'(bus.consumer_read_ready), 64'h0);

    // ---- abort: consumer 2 drops valid while the read is outstanding
    bus.consumer_read_valid[2]   = 1'b1;
    bus.consumer_read_address[2] = 8'h22;
    step();
    chk("abort_issue", 64'(bus.mem_read_valid), 64'h1);
    bus.consumer_read_valid[2] = 1'b0;
    step();
    chk("abort_mem_held", 64'(bus.mem_read_valid), 64'h1);
    bus.mem_read_ready[0] = 1'b1;
    bus.mem_read_data[0]  = 8'h55;
    step();
    bus.mem_read_ready[0] = 1'b0;
    chk("abort_no_ready", 64'(bus.consumer_read_ready), 64'h0);
    chk("abort_valid_off", 64'(bus.mem_read_valid),     64'h0);
    chk("abort_idle",     64'(dut.state_q[0]),          64'(CH_IDLE));
    step();
    chk("abort_still_no", 64'(bus.consumer_read_ready), 64'h0);

    // ---- reset while a writeback is waiting on memory
    bus.consumer_write_valid[6]   = 1'b1;
    bus.consumer_write_address[6] = 8'h44;
    bus.consumer_write_data[6]    = 8'h33;
    step();
    chk("rstw_issue", 64'(bus.mem_write_valid), 64'h1);
    step();
    reset = 1'b0;
    #1;
    chk("rstw_valid", 64'(bus.mem_write_valid),   64'h0);
    chk("rstw_addr",  64'(bus.mem_write_address), 64'h0);
    chk("rstw_data",  64'(bus.mem_write_data),    64'h0);
    chk("rstw_rr",    64'(dut.rr_ptr_q),          64'h0);
    chk("rstw_idle",  64'(dut.state_q[0]),        64'(CH_IDLE));
    clear_inputs();
    step();
    reset = 1'b1;
    step();
    chk("rstw_no_replay_w", 64'(bus.mem_write_valid), 64'h0);
    chk("rstw_no_replay_r", 64'(bus.mem_read_valid),  64'h0);

    // ---- fairness: consumers 0 and 7 keep requesting on a single channel
    bus1.consumer_read_valid[0]   = 1'b1;
    bus1.consumer_read_address[0] = 8'h0A;
    bus1.consumer_read_valid[7]   = 1'b1;
    bus1.consumer_read_address[7] = 8'h7A;
    for (int t = 0; t < 8; t++) begin
      exp_c = (t % 2 == 0) ? 0 : 7;
      exp_a = (t % 2 == 0) ? 8'h0A : 8'h7A;
      step();
      n = 0;
      while (bus1.mem_read_valid[0] !== 1'b1 && n < 8) begin
        step();
        n++;
      end
      chk("fair_issue_in_time", 64'(n < 8), 64'h1);
      chk("fair_grant_addr", 64'(bus1.mem_read_address[0]), 64'(exp_a));
      bus1.mem_read_ready[0] = 1'b1;
      bus1.mem_read_data[0]  = 8'hC0 + 8'(t);
      step();
      bus1.mem_read_ready[0] = 1'b0;
      chk("fair_ready", 64'(bus1.consumer_read_ready), 64'(8'h01 << exp_c));
      bus1.consumer_read_valid[exp_c] = 1'b0;
      step();
      bus1.consumer_read_valid[exp_c] = 1'b1;
    end
    bus1.consumer_read_valid = 8'h00;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
